// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - request/result bundle between the ALU front-end and the shift sequencer
interface shift_sequencer_if #(
  parameter int W  = 4,
  parameter int CW = 3
);
  logic          start;
  logic          dir;
  logic [CW-1:0] amt;
  logic [W-1:0]  d;
  logic [W-1:0]  q;
  logic          busy;
  logic          done;
  logic          step_l;
  logic          step_r;

  modport master (
    output start, dir, amt, d,
    input  q, busy, done, step_l, step_r
  );

  modport slave (
    input  start, dir, amt, d,
    output q, busy, done, step_l, step_r
  );
endinterface

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle logical shifter: one zero-fill bit step per clock
module shift_stage #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_d,
  input  logic         i_l,
  input  logic         i_r,
  output logic [W-1:0] o_q
);
  always_comb begin
    o_q = i_d;
    if (i_l)      o_q = {i_d[W-2:0], 1'b0};
    else if (i_r) o_q = {1'b0, i_d[W-1:1]};
  end
endmodule

module shift_sequencer #(
  parameter int W  = 4,
  parameter int CW = 3
) (
  input  logic               clk,
  input  logic               nrst,
  shift_sequencer_if.slave   bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    r_state;
  logic [W-1:0]  r_q;
  logic [CW-1:0] r_cnt;
  logic          r_dir;
  logic          w_busy;
  logic          w_step_l;
  logic          w_step_r;
  logic [W-1:0]  w_step_q;

  assign w_busy   = (r_state == S_SHIFT);
  assign w_step_l = w_busy & ~r_dir;
  assign w_step_r = w_busy &  r_dir;

  shift_stage #(.W(W)) u_stage (
    .i_d (r_q),
    .i_l (w_step_l),
    .i_r (w_step_r),
    .o_q (w_step_q)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
    end else begin
      case (r_state)
        // DONE accepts a new request just like IDLE so operations can run back-to-back
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_q     <= bus.d;
            r_cnt   <= bus.amt;
            r_dir   <= bus.dir;
            r_state <= (bus.amt != '0) ? S_SHIFT : S_DONE;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_q   <= w_step_q;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.q      = r_q;
  assign bus.busy   = w_busy;
  assign bus.done   = (r_state == S_DONE);
  assign bus.step_l = w_step_l;
  assign bus.step_r = w_step_r;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - randomized and directed checks of shift_sequencer against a behavioural model
module tb_shift_sequencer;
  logic clk;
  logic nrst;
  int   n_checks;
  int   n_err;
  bit   chk_en;

  shift_sequencer_if #(.W(4), .CW(3)) bus ();

  shift_sequencer #(.W(4), .CW(3)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: an accepted request owns amt steps; the result after k steps is d shifted by k.
  logic [3:0] m_d;
  logic       m_dir;
  int         m_left;
  int         m_taken;
  logic       m_done;

  function automatic logic [3:0] shf(input logic [3:0] v, input logic dr, input int n);
    logic [3:0] r;
    if (n >= 4) r = 4'b0000;
    else        r = dr ? (v >> n) : (v << n);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!nrst) begin
      m_d <= 4'b0; m_dir <= 1'b0; m_left <= 0; m_taken <= 0; m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left  <= m_left - 1;
      m_taken <= m_taken + 1;
      m_done  <= (m_left == 1);
    end else if (bus.start) begin
      m_d     <= bus.d;
      m_dir   <= bus.dir;
      m_left  <= int'(bus.amt);
      m_taken <= 0;
      m_done  <= (bus.amt == 3'd0);
    end else begin
      m_done  <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("q",      32'(bus.q),      32'(shf(m_d, m_dir, m_taken)));
      chk("busy",   32'(bus.busy),   32'(m_left > 0));
      chk("done",   32'(bus.done),   32'(m_done));
      chk("step_l", 32'(bus.step_l), 32'((m_left > 0) && !m_dir));
      chk("step_r", 32'(bus.step_r), 32'((m_left > 0) && m_dir));
    end
  end

  task automatic drive(input logic s, input logic dr, input logic [2:0] a, input logic [3:0] dd);
    bus.start = s; bus.dir = dr; bus.amt = a; bus.d = dd;
  endtask

  // Called at a negedge; returns at the negedge where done is visible.
  task automatic wait_done(output int nbusy);
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) break;
      if (bus.busy) nbusy++;
      @(negedge clk);
    end
    if (!bus.done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic op(input logic dr, input logic [2:0] a, input logic [3:0] dd,
                    output int nbusy, output logic [3:0] qf);
    @(negedge clk); drive(1'b1, dr, a, dd);
    @(negedge clk); drive(1'b0, 1'($urandom), 3'($urandom), 4'($urandom));
    wait_done(nbusy);
    qf = bus.q;
  endtask

  int         nb;
  logic [3:0] qf;

  initial begin
    n_checks = 0; n_err = 0; chk_en = 1'b0;
    nrst = 1'b0;
    drive(1'b1, 1'b0, 3'd2, 4'b1011);
    @(posedge clk); chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_q", 32'(bus.q), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_steps", 32'({bus.step_l, bus.step_r}), 32'h0);
    drive(1'b0, 1'b0, 3'd0, 4'b0);
    nrst = 1'b1;

    op(1'b0, 3'd2, 4'b1011, nb, qf);
    chk("left_busy", 32'(nb), 32'd2);
    chk("left_q", 32'(qf), 32'b1100);
    @(negedge clk);
    chk("left_hold_q", 32'(bus.q), 32'b1100);
    chk("left_hold_done", 32'(bus.done), 32'h0);

    op(1'b1, 3'd1, 4'b1011, nb, qf);
    chk("right_busy", 32'(nb), 32'd1);
    chk("right_q", 32'(qf), 32'b0101);

    op(1'b0, 3'd0, 4'b1001, nb, qf);
    chk("zero_busy", 32'(nb), 32'd0);
    chk("zero_q", 32'(qf), 32'b1001);

    op(1'b0, 3'd5, 4'b1111, nb, qf);
    chk("over_busy", 32'(nb), 32'd5);
    chk("over_q", 32'(qf), 32'b0000);

    @(negedge clk); drive(1'b1, 1'b0, 3'd3, 4'b0011);
    @(negedge clk); drive(1'b1, 1'b1, 3'd1, 4'b0001);
    @(negedge clk); drive(1'b0, 1'b0, 3'd0, 4'b0000);
    wait_done(nb);
    chk("protect_q", 32'(bus.q), 32'b1000);
    drive(1'b1, 1'b1, 3'd3, 4'b1000);
    @(negedge clk); drive(1'b0, 1'b0, 3'd0, 4'b0000);
    wait_done(nb);
    chk("b2b_busy", 32'(nb), 32'd3);
    chk("b2b_q", 32'(bus.q), 32'b0001);

    @(negedge clk); drive(1'b1, 1'b0, 3'd4, 4'b1111);
    @(negedge clk); drive(1'b0, 1'b0, 3'd0, 4'b0000);
    @(negedge clk); nrst = 1'b0;
    @(negedge clk); nrst = 1'b1;
    chk("midrst_q", 32'(bus.q), 32'h0);
    chk("midrst_busy", 32'(bus.busy), 32'h0);
    chk("midrst_done", 32'(bus.done), 32'h0);
    @(negedge clk);
    chk("midrst_nodone", 32'(bus.done), 32'h0);
    op(1'b1, 3'd2, 4'b1100, nb, qf);
    chk("after_rst_q", 32'(qf), 32'b0011);

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      drive(($urandom_range(0, 2) == 0), 1'($urandom), 3'($urandom), 4'($urandom));
      nrst = ($urandom_range(0, 60) != 0);
    end
    @(negedge clk); nrst = 1'b1; drive(1'b0, 1'b0, 3'd0, 4'b0);
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle logical shifter controller. Accepts a W-bit operand, a direction and a shift amount, then applies a one-bit logical shift step (zero fill) once per clock until the amount is consumed.
- Step datapath is the team's existing one-bit left/right shift stage, instantiated internally: step_l/step_r drive its l/r controls.
- Start/busy/done handshake; sits between a register file/ALU front-end and the shift stage.

Parameters:
- W, 4, operand/result width in bits.
- CW, 3, shift-amount (and internal counter) width in bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- nrst  input  1  reset, synchronous, active-low.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- dir  input  1  0 = shift left, 1 = shift right; captured with start.
- amt  input  CW  number of one-bit steps; captured with start.
- d  input  W  operand; captured with start.
- q  output  W  result register.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse in DONE.
- step_l  output  1  l control to the shift stage; high in SHIFT when dir_r==0.
- step_r  output  1  r control to the shift stage; high in SHIFT when dir_r==1.

Behaviour:
- Reset (nrst==0 at a clock edge):
  - Synchronous; takes priority over everything, including mid-shift.
  - state=IDLE; q=0, cnt=0, dir_r=0; busy, done, step_l, step_r all 0.
  - Any operation in progress is abandoned, with no done pulse.
- Capture register: dir_r.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 → q<=d, cnt<=amt, dir_r<=dir.
  - Next state is SHIFT if amt!=0, else DONE.
  - start=0 → stay IDLE, q held.
- SHIFT:
  - busy=1.
  - Each edge: q<=shift1(q,dir_r), cnt<=cnt-1.
  - shift1 left = {q[W-2:0],0}; shift1 right = {0,q[W-1:1]}.
  - When cnt==1 at the edge, next state is DONE. Otherwise stay in SHIFT.
  - start ignored; d/amt/dir changes ignored.
- DONE:
  - done=1 for exactly one cycle; q holds the final result.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation).
  - Otherwise the next state is IDLE.
- Outputs:
  - step_l/step_r are never both 1; both are 0 outside SHIFT.
  - step_l = busy & ~dir_r; step_r = busy & dir_r.
- Latency: start sampled at edge E0 → done high during the cycle after edge E0+amt.
  - amt=0 → done after E0+1 with q=d (zero steps).
- Result hold: q holds after DONE until the next accepted start or reset.
- Over-range: amt ≥ W yields q=0 after all steps (zero fill). Still takes amt cycles; no early exit.
- Counter: cnt never decrements below 0. SHIFT is never entered with cnt==0.

Test Plan:
- Reset: nrst=0 for 2 edges with start=1 → q=0000, busy=0, done=0, step_l=step_r=0.
- Left shift: d=1011, dir=0, amt=2, start pulse → busy 2 cycles with step_l=1, q=0110 then 1100; done pulse; q=1100 held in IDLE.
- Right shift: d=1011, dir=1, amt=1 → step_r=1 for one cycle, q=0101, done one cycle later than start+1.
- Zero and over-range amounts:
  - amt=0, d=1001 → no SHIFT cycles, done at first cycle after start, q=1001.
  - amt=5, dir=0, d=1111 → 5 busy cycles, q=0000.
- Busy protection and back-to-back:
  - start with d=0001 during SHIFT of an amt=3 op → ignored, result unchanged.
  - start in DONE cycle (d=1000, dir=1, amt=3) → accepted, final q=0001.
- Reset mid-shift: nrst=0 on 2nd SHIFT cycle of amt=4 op → next cycle IDLE, q=0000, no done pulse; new start afterwards works normally.
